// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one imem request at a time for the current PC and
// returns the fetched word through a stallable, flushable IF/ID register.
module fetch_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_write,
    input  logic            redirect,
    input  logic            id_stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_misaligned,
    output logic [1:0]      fetch_state
);

    // Handshake: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
    // the response is a one-cycle imem_rsp_valid pulse with no back-pressure.
    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_FULL    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            fire;
    logic            can_load;
    logic            load_rsp;
    logic            load_hold;
    logic            park_rsp;
    logic            pc_aligned;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;

    assign fetch_state   = state;
    assign imem_req_addr = pc;
    assign pc_aligned    = (pc[1:0] == 2'b00);
    assign can_load      = !id_stall || !if_id_valid;

    always_comb begin
        next_state     = state;
        imem_req_valid = 1'b0;
        fire           = 1'b0;
        load_rsp       = 1'b0;
        load_hold      = 1'b0;
        park_rsp       = 1'b0;

        case (state)
            ST_ISSUE: begin
                imem_req_valid = !redirect && !if_misaligned && pc_aligned;
                fire           = imem_req_valid && imem_req_ready;
                if (fire) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect) begin
                    next_state = imem_rsp_valid ? ST_ISSUE : ST_DISCARD;
                end else if (imem_rsp_valid) begin
                    load_rsp   = can_load;
                    park_rsp   = !can_load;
                    next_state = can_load ? ST_ISSUE : ST_FULL;
                end
            end
            ST_FULL: begin
                if (redirect) begin
                    next_state = ST_ISSUE;
                end else if (can_load) begin
                    load_hold  = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_DISCARD: begin
                // The owed response is dropped whether or not another redirect arrives.
                if (imem_rsp_valid) next_state = ST_ISSUE;
            end
            default: next_state = ST_ISSUE;
        endcase

        pc_write = fire || redirect;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_ISSUE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_pc <= '0;
        end else if (fire) begin
            pending_pc <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (park_rsp) begin
            hold_pc    <= pending_pc;
            hold_instr <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_misaligned <= 1'b0;
        end else if (redirect) begin
            if_misaligned <= 1'b0;
        end else if (state == ST_ISSUE && !pc_aligned) begin
            if_misaligned <= 1'b1;
        end
    end

    // Redirect flushes IF/ID even when decode is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (redirect) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (load_rsp) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pending_pc;
            if_id_instr <= imem_rsp_data;
        end else if (load_hold) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= hold_pc;
            if_id_instr <= hold_instr;
        end else if (!id_stall) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight-line fetch, stalls, back-pressure,
// redirects, misalignment and reset mid-transaction.
module tb_fetch_stage;

  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [31:0] ST_ISSUE   = 32'd0;
  localparam logic [31:0] ST_WAIT    = 32'd1;
  localparam logic [31:0] ST_FULL    = 32'd2;
  localparam logic [31:0] ST_DISCARD = 32'd3;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_write;
  logic        redirect;
  logic        id_stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_misaligned;
  logic [1:0]  fetch_state;

  int n_cmp;
  int n_err;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_write       (pc_write),
    .redirect       (redirect),
    .id_stall       (id_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_misaligned  (if_misaligned),
    .fetch_state    (fetch_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic rdy, input logic stall,
                       input logic redir, input logic rv, input logic [31:0] rd);
    pc             = p;
    imem_req_ready = rdy;
    id_stall       = stall;
    redirect       = redir;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] p,
                            input logic [31:0] instr);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    if (v) check_eq({tag, ".pc"}, if_id_pc, p);
    check_eq({tag, ".instr"}, if_id_instr, instr);
  endtask

  task automatic check_req(input string tag, input logic rv, input logic pw);
    check_eq({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, rv});
    check_eq({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, pw});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_ifid("reset", 1'b0, 32'h0, NOP);
    check_eq("reset.pc", if_id_pc, 32'h0);
    check_eq("reset.misaligned", {31'd0, if_misaligned}, 32'd0);
    check_eq("reset.state", {30'd0, fetch_state}, ST_ISSUE);

    // straight-line fetch, zero-wait memory
    next_cycle(); reset = 1'b0;
    drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_req("sl_c1", 1'b1, 1'b1);
    check_eq("sl_c1.addr", imem_req_addr, 32'h0);

    next_cycle(); drive(32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00500093);
    @(negedge clk);
    check_req("sl_c2", 1'b0, 1'b0);
    check_eq("sl_c2.state", {30'd0, fetch_state}, ST_WAIT);

    next_cycle(); drive(32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_ifid("sl_c3", 1'b1, 32'h0, 32'h00500093);
    check_req("sl_c3", 1'b1, 1'b1);
    check_eq("sl_c3.addr", imem_req_addr, 32'h4);

    next_cycle(); drive(32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00A00113);
    @(negedge clk);
    check_ifid("sl_c4", 1'b0, 32'h0, NOP);

    // decode stall parks the next word in the hold buffer
    next_cycle(); drive(32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_ifid("st_c5", 1'b1, 32'h4, 32'h00A00113);
    check_req("st_c5", 1'b1, 1'b1);

    next_cycle(); drive(32'hC, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00308193);
    @(negedge clk);
    check_ifid("st_c6", 1'b1, 32'h4, 32'h00A00113);

    next_cycle(); drive(32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("st_c7.state", {30'd0, fetch_state}, ST_FULL);
    check_req("st_c7", 1'b0, 1'b0);
    check_ifid("st_c7", 1'b1, 32'h4, 32'h00A00113);

    next_cycle(); drive(32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("st_c8.state", {30'd0, fetch_state}, ST_FULL);
    check_req("st_c8", 1'b0, 1'b0);

    next_cycle(); drive(32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_ifid("st_c9", 1'b1, 32'h8, 32'h00308193);
    check_eq("st_c9.state", {30'd0, fetch_state}, ST_ISSUE);
    check_req("st_c9", 1'b1, 1'b1);
    check_eq("st_c9.addr", imem_req_addr, 32'hC);

    // redirect while waiting for a response: late word is discarded
    next_cycle(); drive(32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_req("rd_c10", 1'b0, 1'b1);
    check_eq("rd_c10.state", {30'd0, fetch_state}, ST_WAIT);

    next_cycle(); drive(32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("rd_c11.state", {30'd0, fetch_state}, ST_DISCARD);
    check_req("rd_c11", 1'b0, 1'b0);
    check_ifid("rd_c11", 1'b0, 32'h0, NOP);

    next_cycle(); drive(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("rd_c12.state", {30'd0, fetch_state}, ST_ISSUE);
    check_ifid("rd_c12", 1'b0, 32'h0, NOP);
    check_req("rd_c12", 1'b1, 1'b1);
    check_eq("rd_c12.addr", imem_req_addr, 32'h40);

    next_cycle(); drive(32'h44, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000513);
    @(negedge clk);
    check_eq("rd_c13.state", {30'd0, fetch_state}, ST_WAIT);

    // memory back-pressure for three cycles
    next_cycle(); drive(32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_ifid("bp_c14", 1'b1, 32'h40, 32'h00000513);
    check_req("bp_c14", 1'b1, 1'b0);
    check_eq("bp_c14.addr", imem_req_addr, 32'h44);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); drive(32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check_ifid("bp_wait", 1'b0, 32'h0, NOP);
      check_req("bp_wait", 1'b1, 1'b0);
    end
    next_cycle(); drive(32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_req("bp_fire", 1'b1, 1'b1);

    next_cycle(); drive(32'h48, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00100593);
    @(negedge clk);

    // redirect together with a decode stall and a same-cycle response
    next_cycle(); drive(32'h48, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_ifid("rs_c19", 1'b1, 32'h44, 32'h00100593);
    check_req("rs_c19", 1'b1, 1'b1);

    next_cycle(); drive(32'h4C, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBADC0DE0);
    @(negedge clk);
    check_ifid("rs_c20", 1'b1, 32'h44, 32'h00100593);
    check_req("rs_c20", 1'b0, 1'b1);

    next_cycle(); drive(32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_ifid("rs_c21", 1'b0, 32'h0, NOP);
    check_eq("rs_c21.state", {30'd0, fetch_state}, ST_ISSUE);
    check_req("rs_c21", 1'b1, 1'b0);

    // misaligned PC: sticky until redirect
    next_cycle(); drive(32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_req("ma_c22", 1'b0, 1'b0);
    check_eq("ma_c22.misaligned", {31'd0, if_misaligned}, 32'd0);

    next_cycle(); drive(32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("ma_c23.misaligned", {31'd0, if_misaligned}, 32'd1);
    check_req("ma_c23", 1'b0, 1'b0);

    next_cycle(); drive(32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("ma_c24.misaligned", {31'd0, if_misaligned}, 32'd1);
    check_req("ma_c24", 1'b0, 1'b0);

    next_cycle(); drive(32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_req("ma_c25", 1'b0, 1'b1);

    next_cycle(); drive(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("ma_c26.misaligned", {31'd0, if_misaligned}, 32'd0);
    check_req("ma_c26", 1'b1, 1'b1);

    // reset while a response is owed; the late response must be ignored
    next_cycle(); reset = 1'b1;
    drive(32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("rst_c27.state", {30'd0, fetch_state}, ST_WAIT);

    next_cycle(); reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
    @(negedge clk);
    check_eq("rst_c28.state", {30'd0, fetch_state}, ST_ISSUE);
    check_ifid("rst_c28", 1'b0, 32'h0, NOP);
    check_eq("rst_c28.pc", if_id_pc, 32'h0);
    check_eq("rst_c28.misaligned", {31'd0, if_misaligned}, 32'd0);
    check_req("rst_c28", 1'b1, 1'b0);

    next_cycle(); drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_ifid("rst_c29", 1'b0, 32'h0, NOP);
    check_eq("rst_c29.state", {30'd0, fetch_state}, ST_ISSUE);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
